// File: rtl/signed_div_frontend_pkg.sv
// rtl/signed_div_frontend_pkg.sv - shared divider package: FSM states and result constants
package signed_div_frontend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_WAIT,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // Operand is negative only when interpreted as two's complement.
  function automatic logic is_neg(input logic [31:0] x, input logic is_signed);
    return is_signed && ((x & INT_MIN) != 32'h0);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// rtl/cond_negate.sv - two's-complement negate when enabled, modulo 2^W
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         en,
  output logic [W-1:0] dout
);

  assign dout = en ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/signed_div_frontend.sv
// rtl/signed_div_frontend.sv - signed/unsigned wrapper sequencing an external unsigned divider
module signed_div_frontend
  import signed_div_frontend_pkg::*;
(
  input  logic        clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_by_zero,
  output logic        div_rst,
  output logic        div_run,
  output logic [31:0] div_dvnd,
  output logic [31:0] div_dvsr,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_rdy
);

  state_t      state;
  state_t      state_nxt;

  logic        sa;
  logic        sb;
  logic [31:0] q_cap;
  logic [31:0] r_cap;

  logic        in_sa;
  logic        in_sb;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] fix_q;
  logic [31:0] fix_r;
  logic        b_zero;

  assign in_sa  = is_neg(a, is_signed);
  assign in_sb  = is_neg(b, is_signed);
  assign b_zero = (b == 32'h0);

  cond_negate #(.W(32)) u_neg_a (.din(a),     .en(in_sa),   .dout(mag_a));
  cond_negate #(.W(32)) u_neg_b (.din(b),     .en(in_sb),   .dout(mag_b));
  cond_negate #(.W(32)) u_fix_q (.din(q_cap), .en(sa ^ sb), .dout(fix_q));
  cond_negate #(.W(32)) u_fix_r (.din(r_cap), .en(sa),      .dout(fix_r));

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = b_zero ? ST_DONE : ST_CLR;
      ST_CLR:  state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_WAIT;
      ST_WAIT: if (div_rdy) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign div_run    = (state == ST_RUN);
  // The divider is cleared together with the frontend as well as before each run.
  assign div_rst    = Rst || (state == ST_CLR);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      sa          <= 1'b0;
      sb          <= 1'b0;
      div_dvnd    <= 32'h0;
      div_dvsr    <= 32'h0;
      q_cap       <= 32'h0;
      r_cap       <= 32'h0;
      quot        <= 32'h0;
      rem         <= 32'h0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            sa       <= in_sa;
            sb       <= in_sb;
            div_dvnd <= mag_a;
            div_dvsr <= mag_b;
            // A zero divisor bypasses the divider entirely.
            if (b_zero) begin
              quot        <= DIV_ZERO_QUOT;
              rem         <= a;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (div_rdy) begin
            q_cap <= div_q;
            r_cap <= div_r;
          end
        end
        ST_FIX: begin
          quot <= fix_q;
          rem  <= fix_r;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_frontend.sv
// tb/tb_signed_div_frontend.sv - randomized self-checking bench with behavioural unsigned divider
module tb_signed_div_frontend;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        is_signed = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;
  logic        div_rst;
  logic        div_run;
  logic [31:0] div_dvnd;
  logic [31:0] div_dvsr;
  logic [31:0] div_q = 32'h0;
  logic [31:0] div_r = 32'h0;
  logic        div_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  signed_div_frontend dut (
    .clk(clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .is_signed(is_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero),
    .div_rst(div_rst), .div_run(div_run),
    .div_dvnd(div_dvnd), .div_dvsr(div_dvsr),
    .div_q(div_q), .div_r(div_r), .div_rdy(div_rdy)
  );

  always #5 clk = ~clk;

  // Downstream unsigned divider: result appears div_lat cycles after Run, level until cleared.
  int div_lat = 1;
  int m_cnt = 0;
  logic m_busy = 1'b0;
  always @(posedge clk) begin
    if (div_rst) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      div_rdy <= 1'b0;
    end else if (div_run) begin
      m_busy  <= 1'b1;
      m_cnt   <= div_lat;
      div_rdy <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy  <= 1'b0;
        div_rdy <= 1'b1;
        div_q   <= (div_dvsr != 0) ? div_dvnd / div_dvsr : 32'hFFFF_FFFF;
        div_r   <= (div_dvsr != 0) ? div_dvnd % div_dvsr : div_dvnd;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int run_cnt = 0;
  int overlap = 0;
  always @(posedge clk) begin
    if (div_run) run_cnt <= run_cnt + 1;
    if (div_rst && div_run) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers, then wrapped to 32 bits.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint xl;
    longint yl;
    if (y == 0) begin
      q = 32'hFFFF_FFFF;
      r = x;
      z = 1'b1;
    end else begin
      xl = s ? {{32{x[31]}}, x} : {32'h0, x};
      yl = s ? {{32{y[31]}}, y} : {32'h0, y};
      q = 32'(xl / yl);
      r = 32'(xl % yl);
      z = 1'b0;
    end
  endtask

  logic [31:0] exp_q;
  logic [31:0] exp_r;
  logic        exp_z;
  int          exp_lat;
  int          runs_before;

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s, input int lat);
    @(negedge clk);
    div_lat   = lat;
    a         = x;
    b         = y;
    is_signed = s;
    req_valid = 1'b1;
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    ref_div(x, y, s, exp_q, exp_r, exp_z);
    exp_lat     = (y == 0) ? 1 : lat + 5;
    runs_before = run_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    a         = $urandom;
    b         = $urandom;
  endtask

  task automatic wait_resp(input string tag);
    int cyc;
    cyc = 1;
    while (!resp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_quot"}, quot, exp_q);
    check({tag, "_rem"}, rem, exp_r);
    check({tag, "_dbz"}, {31'h0, div_by_zero}, {31'h0, exp_z});
    if (exp_z) check({tag, "_no_run"}, run_cnt - runs_before, 0);
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("req_ready_after_resp", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                    input logic s, input int lat);
    send(x, y, s, lat);
    wait_resp(tag);
    release_resp();
  endtask

  initial begin
    int guard;
    logic [31:0] held_q;
    logic [31:0] held_r;
    logic [31:0] ra;
    logic [31:0] rb;
    logic rs;

    #1;
    check("rst_div_rst", {31'h0, div_rst}, 32'h1);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_quot", quot, 32'h0);
    check("rst_dvnd", div_dvnd, 32'h0);
    repeat (2) @(negedge clk);
    Rst = 1'b0;

    op("neg7_div2_s", 32'hFFFF_FFF9, 32'd2, 1'b1, 3);
    op("neg7_div2_u", 32'hFFFF_FFF9, 32'd2, 1'b0, 2);
    op("div0", 32'd100, 32'd0, 1'b0, 4);
    op("intmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);

    // Reset while the divider is busy must abandon the operation cleanly.
    send(32'd50, 32'd7, 1'b0, 6);
    guard = 0;
    while (run_cnt == runs_before && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("reached_wait", {31'h0, (run_cnt != runs_before)}, 32'h1);
    #2 Rst = 1'b1;
    #1;
    check("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("mid_rst_quot", quot, 32'h0);
    check("mid_rst_rem", rem, 32'h0);
    check("mid_rst_dbz", {31'h0, div_by_zero}, 32'h0);
    check("mid_rst_run", {31'h0, div_run}, 32'h0);
    check("mid_rst_dvnd", div_dvnd, 32'h0);
    check("mid_rst_dvsr", div_dvsr, 32'h0);
    check("mid_rst_div_rst", {31'h0, div_rst}, 32'h1);
    repeat (2) @(negedge clk);
    Rst = 1'b0;
    op("after_rst", 32'd50, 32'd7, 1'b0, 3);

    // Result held under backpressure while a new request waits.
    send(32'd1000, 32'hFFFF_FFFD, 1'b1, 2);
    wait_resp("held");
    held_q = quot;
    held_r = rem;
    a = 32'd77;
    b = 32'd5;
    is_signed = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held_quot", quot, exp_q);
      check("held_rem", rem, exp_r);
    end
    check("held_req_ready", {31'h0, req_ready}, 32'h0);
    check("held_resp_valid", {31'h0, resp_valid}, 32'h1);
    ref_div(32'd77, 32'd5, 1'b0, exp_q, exp_r, exp_z);
    div_lat = 2;
    exp_lat = 7;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("second_req_ready", {31'h0, req_ready}, 32'h1);
    runs_before = run_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp("second");
    release_resp();

    for (int n = 0; n < 30; n++) begin
      rs = 1'($urandom);
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = 32'h0; end
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
        2: begin
          ra = $urandom_range(0, 200);
          rb = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) ra = -ra;
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      op("rand", ra, rb, rs, $urandom_range(1, 6));
    end

    check("rst_run_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
